// File: rtl/id_writeback_scoreboard.sv
// ---------------------------------------------------------------------------
// id_writeback_scoreboard
//
// Keeps a count of the writes still in flight for every architectural
// register, for use by the ID stage. An instruction whose source register
// still has a write pending is held in ID by raising stall. An instruction is
// also held when its destination counter is already at its maximum. Each
// writeback lowers the count for its register by one. The last register
// (XZR) is never tracked.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   issue_valid                     ID presents an instruction this cycle
//   issue_rf1 / issue_rf1_used      first source register and its read flag
//   issue_rf2 / issue_rf2_used      second source register and its read flag
//   issue_rd / issue_regwrite       destination register and its write flag
//   stall                           combinational; hold the instruction in ID
//   wb_valid / wb_rd                one register write retires this cycle
//   flush                           pipeline squash; clears all pending state
//   pending                         registered; bit r = counter r non-zero
//   idle                            registered; every counter is zero
//   underflow_err                   sticky; a retire hit a zero counter
// ---------------------------------------------------------------------------
module id_writeback_scoreboard #(
    parameter int CNT_W    = 2,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rf1,
    input  logic                        issue_rf1_used,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rf2,
    input  logic                        issue_rf2_used,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic                        issue_regwrite,
    output logic                        stall,
    input  logic                        wb_valid,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic                        flush,
    output logic [NUM_REGS-1:0]         pending,
    output logic                        idle,
    output logic                        underflow_err
);

    localparam int                IDX_W   = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0]  XZR     = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_reg  [NUM_REGS];
    logic [CNT_W-1:0]    cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] pending_next;
    logic [NUM_REGS-1:0] underflow_hit;

    logic hz1;
    logic hz2;
    logic full;
    logic accept;
    logic ret;

    // Hazard checks read the registered counters only, so a retire in the
    // same cycle never releases a stall before the following cycle.
    assign hz1  = issue_rf1_used && (issue_rf1 != XZR) && (cnt_reg[issue_rf1] != '0);
    assign hz2  = issue_rf2_used && (issue_rf2 != XZR) && (cnt_reg[issue_rf2] != '0);
    assign full = issue_regwrite && (issue_rd != XZR) && (cnt_reg[issue_rd] == CNT_MAX);

    assign stall  = issue_valid && (hz1 || hz2 || full) && !flush;
    assign accept = issue_valid && !stall && !flush && issue_regwrite && (issue_rd != XZR);
    assign ret    = wb_valid && (wb_rd != XZR) && !flush;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == NUM_REGS - 1) begin : g_xzr
                assign cnt_next[gi]      = '0;
                assign pending_next[gi]  = 1'b0;
                assign underflow_hit[gi] = 1'b0;
            end else begin : g_trk
                logic             inc;
                logic             dec;
                logic             is_zero;
                logic [CNT_W-1:0] nxt;

                assign inc     = accept && (issue_rd == IDX_W'(gi));
                assign dec     = ret && (wb_rd == IDX_W'(gi));
                assign is_zero = (cnt_reg[gi] == '0);

                always_comb begin
                    nxt = cnt_reg[gi];
                    if (flush) begin
                        nxt = '0;
                    end else begin
                        case ({inc, dec})
                            2'b10:   nxt = cnt_reg[gi] + CNT_ONE;
                            2'b01:   nxt = is_zero ? '0 : cnt_reg[gi] - CNT_ONE;
                            // Both hit: they cancel, except that a retire to
                            // an empty counter is dropped and the issue still
                            // counts.
                            2'b11:   nxt = is_zero ? CNT_ONE : cnt_reg[gi];
                            default: nxt = cnt_reg[gi];
                        endcase
                    end
                end

                assign cnt_next[gi]      = nxt;
                assign pending_next[gi]  = (nxt != '0);
                assign underflow_hit[gi] = dec && is_zero;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_reg[i] <= '0;
            end
            pending       <= '0;
            idle          <= 1'b1;
            underflow_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            pending       <= pending_next;
            idle          <= ~|pending_next;
            underflow_err <= underflow_err | (|underflow_hit);
        end
    end

endmodule

// File: tb/tb_id_writeback_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_writeback_scoreboard
//
// Directed table of per-cycle vectors with hand-computed expectations. The
// stall value is checked before the clock edge. The pending, idle and
// underflow_err values are checked after the edge. A hand-written sequence
// follows, which covers a mid-run asynchronous reset.
// ---------------------------------------------------------------------------
module tb_id_writeback_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  issue_rf1;
    logic        issue_rf1_used;
    logic [4:0]  issue_rf2;
    logic        issue_rf2_used;
    logic [4:0]  issue_rd;
    logic        issue_regwrite;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] pending;
    logic        idle;
    logic        underflow_err;

    int total = 0;
    int bad   = 0;

    id_writeback_scoreboard #(.CNT_W(2), .NUM_REGS(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_rf1      (issue_rf1),
        .issue_rf1_used (issue_rf1_used),
        .issue_rf2      (issue_rf2),
        .issue_rf2_used (issue_rf2_used),
        .issue_rd       (issue_rd),
        .issue_regwrite (issue_regwrite),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .pending        (pending),
        .idle           (idle),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rf1;
        logic        u1;
        logic [4:0]  rf2;
        logic        u2;
        logic [4:0]  rd;
        logic        rw;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl;
        logic        exp_stall;
        logic [31:0] exp_pend;
        logic        exp_idle;
        logic        exp_uf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [4:0] rf1, logic u1, logic [4:0] rf2,
                                logic u2, logic [4:0] rd, logic rw, logic wv,
                                logic [4:0] wrd, logic fl, logic st, logic [31:0] pd,
                                logic il, logic uf);
        vec_t v;
        v.iv = iv;  v.rf1 = rf1; v.u1 = u1; v.rf2 = rf2; v.u2 = u2;
        v.rd = rd;  v.rw = rw;   v.wv = wv; v.wrd = wrd; v.fl = fl;
        v.exp_stall = st; v.exp_pend = pd; v.exp_idle = il; v.exp_uf = uf;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid    = v.iv;
        issue_rf1      = v.rf1;
        issue_rf1_used = v.u1;
        issue_rf2      = v.rf2;
        issue_rf2_used = v.u2;
        issue_rd       = v.rd;
        issue_regwrite = v.rw;
        wb_valid       = v.wv;
        wb_rd          = v.wrd;
        flush          = v.fl;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0));
    endtask

    initial begin
        //           iv rf1 u1 rf2 u2 rd rw wv wrd fl  stall pending       idle uf
        // RAW stall, released the cycle after the retire edge
        tbl.push_back(mk(1,  1, 1,  0, 0,  3, 1, 0,  0, 0, 0, 32'h0000_0008, 0, 0));
        tbl.push_back(mk(1,  3, 1,  0, 0, 10, 1, 0,  0, 0, 1, 32'h0000_0008, 0, 0));
        tbl.push_back(mk(1,  3, 1,  0, 0, 10, 1, 1,  3, 0, 1, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1,  3, 1,  0, 0, 10, 1, 0,  0, 0, 0, 32'h0000_0400, 0, 0));
        tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 1, 10, 0, 0, 32'h0000_0000, 1, 0));
        // XZR: never tracked, never stalls, retire to it is not an underflow
        tbl.push_back(mk(1, 31, 1, 31, 1, 31, 1, 0,  0, 0, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 1, 31, 0, 0, 32'h0000_0000, 1, 0));
        // Counter full on rd=5: three accepted, the fourth stalls
        tbl.push_back(mk(1,  0, 0,  0, 0,  5, 1, 0,  0, 0, 0, 32'h0000_0020, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  5, 1, 0,  0, 0, 0, 32'h0000_0020, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  5, 1, 0,  0, 0, 0, 32'h0000_0020, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  5, 1, 0,  0, 0, 1, 32'h0000_0020, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  5, 1, 1,  5, 0, 1, 32'h0000_0020, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  5, 1, 0,  0, 0, 0, 32'h0000_0020, 0, 0));
        // Simultaneous issue/retire: different registers, then the same one
        tbl.push_back(mk(1,  0, 0,  0, 0,  7, 1, 1,  5, 0, 0, 32'h0000_00A0, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  7, 1, 1,  7, 0, 0, 32'h0000_00A0, 0, 0));
        tbl.push_back(mk(1,  0, 0,  7, 1,  1, 1, 0,  0, 0, 1, 32'h0000_00A0, 0, 0));
        // Flush masks the stall and clears everything
        tbl.push_back(mk(1,  7, 1,  0, 0,  9, 1, 0,  0, 1, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  1, 1, 0,  0, 0, 0, 32'h0000_0002, 0, 0));
        tbl.push_back(mk(1,  1, 0,  0, 0,  2, 1, 0,  0, 0, 0, 32'h0000_0006, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  4, 1, 0,  0, 0, 0, 32'h0000_0016, 0, 0));
        tbl.push_back(mk(1,  0, 0,  0, 0,  9, 1, 1,  4, 1, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 1, 12, 1, 0, 32'h0000_0000, 1, 0));
        tbl.push_back(mk(1,  9, 1,  0, 0, 31, 1, 0,  0, 0, 0, 32'h0000_0000, 1, 0));
        // Underflow: sticky; a same-cycle issue to an empty register still counts
        tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 1,  4, 0, 0, 32'h0000_0000, 1, 1));
        tbl.push_back(mk(1,  0, 0,  0, 0,  6, 1, 1,  6, 0, 0, 32'h0000_0040, 0, 1));
        tbl.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0, 32'h0000_0040, 0, 1));

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_pending", -1, pending, 32'h0);
        chk("reset_idle", -1, {31'b0, idle}, 32'h1);
        chk("reset_uf", -1, {31'b0, underflow_err}, 32'h0);
        chk("reset_stall", -1, {31'b0, stall}, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk("stall", i, {31'b0, stall}, {31'b0, tbl[i].exp_stall});
            @(posedge clk);
            #1;
            chk("pending", i, pending, tbl[i].exp_pend);
            chk("idle", i, {31'b0, idle}, {31'b0, tbl[i].exp_idle});
            chk("underflow", i, {31'b0, underflow_err}, {31'b0, tbl[i].exp_uf});
            $display("step %0d stall=%b pending=%h idle=%b uf=%b",
                     i, stall, pending, idle, underflow_err);
        end

        // Mid-run asynchronous reset: outputs clear without waiting for a clock
        @(negedge clk);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pending", 100, pending, 32'h0);
        chk("async_rst_idle", 100, {31'b0, idle}, 32'h1);
        chk("async_rst_uf", 100, {31'b0, underflow_err}, 32'h0);
        $display("async reset pending=%h idle=%b uf=%b", pending, idle, underflow_err);
        @(negedge clk);
        rst_n = 1'b1;

        // Operation resumes normally after reset; the old rd=6 entry is gone
        @(negedge clk);
        drive(mk(1, 6, 1, 0, 0, 3, 1, 0, 0, 0, 0, 32'h0, 0, 0));
        #1;
        chk("post_rst_stall", 101, {31'b0, stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_pending", 101, pending, 32'h0000_0008);
        chk("post_rst_idle", 101, {31'b0, idle}, 32'h0);
        $display("post reset issue pending=%h idle=%b", pending, idle);

        @(negedge clk);
        drive_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
